// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit packed-BCD adder built around one decimal digit
// adder. Operands are accepted on a valid/ready handshake and processed one digit
// per clock, least-significant digit first. The carry passes between digits
// through a register. The result is returned on a valid/ready handshake.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, cin            packed BCD operands (digit 0 in [3:0]) and carry-in
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   sum, cout            packed BCD sum and decimal carry out of the top digit
//   invalid              some input digit of a or b was greater than 9
module bcd_serial_adder #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  invalid
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic            invalid_q, invalid_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;

   logic            accept;
   logic            last_digit;
   logic            in_bad;
   logic [4:0]      digit_sum;
   logic [3:0]      digit_out;
   logic            digit_carry;

   // State register and all datapath flops; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         invalid_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         invalid_q   <= invalid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready_q is low during reset, so the first cycle out of reset cannot accept.
   assign accept     = (state_q == IDLE) && in_valid && in_ready_q;
   assign last_digit = (cnt_q == LAST_DIGIT);

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ADD;
         ADD:     if (last_digit) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pseudo-tetrade detection over every digit of both operands.
   always_comb begin
      in_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
            in_bad = 1'b1;
         end
      end
   end

   // Single decimal digit adder on the low digit of the operand shift registers.
   // Adding 6 modulo 16 skips the six unused codes when the digit overflows.
   always_comb begin
      digit_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
      if (digit_sum > 5'd9) begin
         digit_out   = digit_sum[3:0] + 4'd6;
         digit_carry = 1'b1;
      end else begin
         digit_out   = digit_sum[3:0];
         digit_carry = 1'b0;
      end
   end

   // Output and datapath control.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      invalid_d   = invalid_q;
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d       = a;
               b_d       = b;
               carry_d   = cin;
               cnt_d     = '0;
               invalid_d = in_bad;
               sum_d     = '0;
               cout_d    = 1'b0;
            end
         end
         ADD: begin
            // Result digits enter at the top; after DIGITS shifts digit 0 sits in [3:0].
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            sum_d   = (sum_q >> 4) | (W'(digit_out) << (W - 4));
            carry_d = digit_carry;
            cnt_d   = cnt_q + CW'(1);
            if (last_digit) begin
               cout_d = digit_carry;
            end
         end
         default: begin
         end
      endcase
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 4 * DIGITS;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          invalid;

   int n_checks = 0;
   int n_errors = 0;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .invalid   (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one operand pair for a single edge, scrambles the inputs afterwards,
   // then waits (bounded) for out_valid; lat = edges from accept to out_valid.
   task automatic run_add(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, output int lat);
      in_valid = 1'b1;
      a = va; b = vb; cin = vc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = '1; b = '1; cin = 1'b1;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (sum !== 16'h0000) begin n_errors++; $display("FAIL reset_sum got %h want 0000", sum); end
      n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout got %b want 0", cout); end
      n_checks++; if (invalid !== 1'b0) begin n_errors++; $display("FAIL reset_invalid got %b want 0", invalid); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic_add();
      logic [W-1:0] ta [5] = '{16'h1234, 16'h9999, 16'h9999, 16'h0000, 16'h5000};
      logic [W-1:0] tb [5] = '{16'h5678, 16'h0001, 16'h9999, 16'h0000, 16'h5000};
      logic         tc [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
      logic [W-1:0] es [5] = '{16'h6912, 16'h0000, 16'h9999, 16'h0001, 16'h0000};
      logic         ec [5] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
      int lat;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready[%0d] got %b want 1", i, in_ready); end
         run_add(ta[i], tb[i], tc[i], lat);
         n_checks++; if (lat !== DIGITS) begin n_errors++; $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, DIGITS); end
         n_checks++; if (sum !== es[i]) begin n_errors++; $display("FAIL basic_sum[%0d] got %h want %h", i, sum, es[i]); end
         n_checks++; if (cout !== ec[i]) begin n_errors++; $display("FAIL basic_cout[%0d] got %b want %b", i, cout, ec[i]); end
         n_checks++; if (invalid !== 1'b0) begin n_errors++; $display("FAIL basic_invalid[%0d] got %b want 0", i, invalid); end
         release_result();
         n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_valid_drop[%0d] got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_invalid();
      int lat;
      run_add(16'h00A0, 16'h0000, 1'b0, lat);
      n_checks++; if (lat !== DIGITS) begin n_errors++; $display("FAIL inv_latency got %0d want %0d", lat, DIGITS); end
      n_checks++; if (invalid !== 1'b1) begin n_errors++; $display("FAIL inv_flag got %b want 1", invalid); end
      n_checks++; if (sum !== 16'h0100) begin n_errors++; $display("FAIL inv_sum got %h want 0100", sum); end
      n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL inv_cout got %b want 0", cout); end
      release_result();
      run_add(16'h0001, 16'h0002, 1'b0, lat);
      n_checks++; if (invalid !== 1'b0) begin n_errors++; $display("FAIL inv_clear got %b want 0", invalid); end
      n_checks++; if (sum !== 16'h0003) begin n_errors++; $display("FAIL inv_next_sum got %h want 0003", sum); end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      run_add(16'h1111, 16'h2222, 1'b0, lat);
      n_checks++; if (sum !== 16'h3333) begin n_errors++; $display("FAIL bp_sum got %h want 3333", sum); end
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         a = 16'h9999; b = 16'h8888; cin = 1'b1;
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, out_valid); end
         n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold_ready[%0d] got %b want 0", i, in_ready); end
         n_checks++; if (sum !== 16'h3333) begin n_errors++; $display("FAIL bp_hold_sum[%0d] got %h want 3333", i, sum); end
         n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL bp_hold_cout[%0d] got %b want 0", i, cout); end
      end
      // Result taken while a new operand is already offered: no accept on this edge.
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 16'h0042; b = 16'h0001; cin = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      run_add(16'h0042, 16'h0001, 1'b0, lat);
      n_checks++; if (lat !== DIGITS) begin n_errors++; $display("FAIL bp_next_latency got %0d want %0d", lat, DIGITS); end
      n_checks++; if (sum !== 16'h0043) begin n_errors++; $display("FAIL bp_next_sum got %h want 0043", sum); end
      release_result();
   endtask

   task automatic test_reset_mid_add();
      int lat;
      bit seen;
      in_valid = 1'b1;
      a = 16'h00A0; b = 16'h1111; cin = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (invalid !== 1'b1) begin n_errors++; $display("FAIL rmid_invalid_set got %b want 1", invalid); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
      n_checks++; if (sum !== 16'h0000) begin n_errors++; $display("FAIL rmid_sum got %h want 0000", sum); end
      n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL rmid_cout got %b want 0", cout); end
      n_checks++; if (invalid !== 1'b0) begin n_errors++; $display("FAIL rmid_invalid got %b want 0", invalid); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rmid_no_result got %b want 0", seen); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rmid_idle_ready got %b want 1", in_ready); end
      run_add(16'h0005, 16'h0005, 1'b0, lat);
      n_checks++; if (lat !== DIGITS) begin n_errors++; $display("FAIL rmid_next_latency got %0d want %0d", lat, DIGITS); end
      n_checks++; if (sum !== 16'h0010) begin n_errors++; $display("FAIL rmid_next_sum got %h want 0010", sum); end
      n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL rmid_next_cout got %b want 0", cout); end
      release_result();
   endtask

   // out_ready held high and in_valid held high: one result every DIGITS+2 cycles.
   task automatic test_back_to_back();
      logic [W-1:0] ta [3] = '{16'h0123, 16'h9000, 16'h4321};
      logic [W-1:0] tb [3] = '{16'h0456, 16'h1000, 16'h5678};
      logic [W-1:0] es [3] = '{16'h0579, 16'h0000, 16'h9999};
      logic         ec [3] = '{1'b0,     1'b1,     1'b0};
      int  idx = 0;
      int  k = 0;
      int  prev = -1;
      bit  acc;
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = ta[0]; b = tb[0]; cin = 1'b0;
      for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               a = ta[idx]; b = tb[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            n_checks++; if (sum !== es[k]) begin n_errors++; $display("FAIL b2b_sum[%0d] got %h want %h", k, sum, es[k]); end
            n_checks++; if (cout !== ec[k]) begin n_errors++; $display("FAIL b2b_cout[%0d] got %b want %b", k, cout, ec[k]); end
            if (k > 0) begin
               n_checks++; if (cyc - prev !== DIGITS + 2) begin n_errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", k, cyc - prev, DIGITS + 2); end
            end
            prev = cyc;
            k++;
         end
      end
      n_checks++; if (k !== 3) begin n_errors++; $display("FAIL b2b_count got %0d want 3", k); end
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      test_reset();
      test_basic_add();
      test_invalid();
      test_backpressure();
      test_reset_mid_add();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
